// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync monitor: checks hsync/vsync timing, runs a lock FSM
// and recovers pixel coordinates plus colour for on-chip capture and self-test.
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [1:0]  pix_r,
  output logic [1:0]  pix_g,
  output logic [1:0]  pix_b,
  output logic        frame_start,
  output logic [7:0]  err_count,
  output logic [10:0] line_len_meas,
  output logic [9:0]  frame_lines_meas
);

  localparam int unsigned HCW = 11;
  localparam int unsigned VCW = 10;
  localparam int unsigned GW  = 4;

  // Visible window ends at the earlier of sync+back+active and total-front.
  localparam int unsigned H_VIS0_I = H_SYNC + H_BACK;
  localparam int unsigned H_VIS1_A = H_VIS0_I + H_ACTIVE;
  localparam int unsigned H_VIS1_B = H_TOTAL - H_FRONT;
  localparam int unsigned H_VIS1_I = (H_VIS1_A < H_VIS1_B) ? H_VIS1_A : H_VIS1_B;
  localparam int unsigned V_VIS0_I = V_SYNC + V_BACK;
  localparam int unsigned V_VIS1_A = V_VIS0_I + V_ACTIVE;
  localparam int unsigned V_VIS1_B = V_TOTAL - V_FRONT;
  localparam int unsigned V_VIS1_I = (V_VIS1_A < V_VIS1_B) ? V_VIS1_A : V_VIS1_B;

  localparam logic [HCW-1:0] H_MAX      = '1;
  localparam logic [VCW-1:0] V_MAX      = '1;
  localparam logic [HCW-1:0] H_VIS0     = HCW'(H_VIS0_I);
  localparam logic [HCW-1:0] H_VIS1     = HCW'(H_VIS1_I);
  localparam logic [VCW-1:0] V_VIS0     = VCW'(V_VIS0_I);
  localparam logic [VCW-1:0] V_VIS1     = VCW'(V_VIS1_I);
  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SYNC_C   = HCW'(H_SYNC);
  localparam logic [VCW-1:0] V_TOTAL_C  = VCW'(V_TOTAL);
  localparam logic [VCW-1:0] V_SYNC_C   = VCW'(V_SYNC);
  localparam logic [GW-1:0]  LOCK_N     = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t          state;
  logic            hs_s1, vs_s1, hs_d, vs_d;
  logic [1:0]      r_s1, g_s1, b_s1;
  logic [HCW-1:0]  h_cnt;
  logic [VCW-1:0]  v_cnt;
  logic [GW-1:0]   good;
  logic            frame_bad;

  logic            h_fall, h_rise, v_fall, v_rise;
  logic [HCW-1:0]  h_inc, h_now;
  logic [VCW-1:0]  v_inc, v_lines, v_now;
  logic            chk_err, timeout, bad_now, frame_clean;
  logic            visible, verify_lock, lock_nxt;
  logic [GW-1:0]   good_inc;

  // Stage 1: input registers plus previous sync values for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s1 <= 1'b1;
      vs_s1 <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      r_s1  <= '0;
      g_s1  <= '0;
      b_s1  <= '0;
    end else begin
      hs_s1 <= hsync_in;
      vs_s1 <= vsync_in;
      hs_d  <= hs_s1;
      vs_d  <= vs_s1;
      r_s1  <= r_in;
      g_s1  <= g_in;
      b_s1  <= b_in;
    end
  end

  // h_now/v_now are the counts of the sample currently in stage 1
  always_comb begin
    h_fall   = hs_d & ~hs_s1;
    h_rise   = ~hs_d & hs_s1;
    v_fall   = vs_d & ~vs_s1;
    v_rise   = ~vs_d & vs_s1;
    h_inc    = (h_cnt == H_MAX) ? H_MAX : h_cnt + HCW'(1);
    h_now    = h_fall ? '0 : h_inc;
    v_inc    = (v_cnt == V_MAX) ? V_MAX : v_cnt + VCW'(1);
    v_lines  = h_fall ? v_inc : v_cnt;
    v_now    = v_fall ? '0 : v_lines;
    chk_err  = (h_fall && (h_cnt != H_LAST))      ||
               (h_rise && (h_now != H_SYNC_C))    ||
               (v_fall && (v_lines != V_TOTAL_C)) ||
               (v_rise && (v_now != V_SYNC_C));
    timeout  = ((h_now == H_MAX) && (h_cnt != H_MAX)) ||
               ((v_now == V_MAX) && (v_cnt != V_MAX));
    bad_now  = chk_err | timeout;
    frame_clean = ~(frame_bad | chk_err);
    good_inc = good + GW'(1);
    visible  = (h_now >= H_VIS0) && (h_now < H_VIS1) &&
               (v_now >= V_VIS0) && (v_now < V_VIS1);
    verify_lock = (state == VERIFY) && v_fall && !timeout && frame_clean &&
                  (good_inc == LOCK_N);
    lock_nxt = verify_lock || ((state == LOCKED) && !bad_now);
  end

  // Timing counters and measurements
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt            <= '0;
      v_cnt            <= '0;
      line_len_meas    <= '0;
      frame_lines_meas <= '0;
    end else begin
      h_cnt <= h_now;
      v_cnt <= v_now;
      if (h_fall) line_len_meas <= h_inc;
      if (v_fall) frame_lines_meas <= v_lines;
    end
  end

  // Lock FSM; frame_bad collects errors between vsync falls
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      good      <= '0;
      frame_bad <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      locked <= lock_nxt;
      if (v_fall) frame_bad <= 1'b0;
      else if (bad_now) frame_bad <= 1'b1;
      case (state)
        SEARCH: begin
          if (v_fall) begin
            state <= VERIFY;
            good  <= '0;
          end
        end
        VERIFY: begin
          if (timeout) begin
            state <= SEARCH;
          end else if (v_fall) begin
            if (!frame_clean) good <= '0;
            else if (verify_lock) state <= LOCKED;
            else good <= good_inc;
          end
        end
        LOCKED: begin
          if (bad_now) begin
            state <= SEARCH;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Stage 2: pixel outputs, held while no pixel is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
    end else begin
      pix_valid   <= visible && lock_nxt;
      frame_start <= visible && lock_nxt && (h_now == H_VIS0) && (v_now == V_VIS0);
      if (visible && lock_nxt) begin
        pix_x <= 10'(h_now - H_VIS0);
        pix_y <= 10'(v_now - V_VIS0);
        pix_r <= r_s1;
        pix_g <= g_s1;
        pix_b <= b_s1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster (15x9) with a built-in
// sync generator, pixel scoreboard and a table of stream scenarios.
module tb_vga_sync_monitor;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = 9;
  localparam int LF = 2;

  logic        clk, rst, hsync_in, vsync_in;
  logic [1:0]  r_in, g_in, b_in;
  logic        locked, pix_valid, frame_start;
  logic [9:0]  pix_x, pix_y, frame_lines_meas;
  logic [1:0]  pix_r, pix_g, pix_b;
  logic [7:0]  err_count;
  logic [10:0] line_len_meas;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_start(frame_start),
    .err_count(err_count), .line_len_meas(line_len_meas),
    .frame_lines_meas(frame_lines_meas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          vis;
    int          x;
    int          y;
    logic [1:0]  r, g, b;
  } px_t;

  typedef struct {
    string name;
    int    mode;
    int    frames;
    int    exp_locked;
    int    exp_err;
    int    exp_llm;
    int    exp_flm;
    int    exp_pix;
    int    exp_fs;
  } vec_t;

  int  checks, errors;
  int  gh, gv, long_line, vs_lines, frames_done;
  bit  idle;
  int  fpix, ffs, last_fpix, last_ffs;
  px_t h1, h2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] colour(input int x, input int y);
    if (x == 0 && y == 0) return {2'd3, 2'd2, 2'd1};
    if (x == HA - 1 && y == VA - 1) return {2'd1, 2'd0, 2'd2};
    return {2'(x), 2'(y), 2'(x + y)};
  endfunction

  // One pixel clock: score outputs at the negedge, then drive the next sample
  task automatic step();
    px_t cur;
    logic [5:0] c;
    @(negedge clk);
    if (pix_valid) begin
      fpix++;
      checks++;
      if (!h2.vis || pix_x != 10'(h2.x) || pix_y != 10'(h2.y) ||
          pix_r != h2.r || pix_g != h2.g || pix_b != h2.b) begin
        errors++;
        $display("FAIL pixel: got x=%0d y=%0d rgb=%0d,%0d,%0d expected vis=%0d x=%0d y=%0d rgb=%0d,%0d,%0d",
                 pix_x, pix_y, pix_r, pix_g, pix_b, h2.vis, h2.x, h2.y, h2.r, h2.g, h2.b);
      end
    end
    if (frame_start) begin
      ffs++;
      check("frame_start_at_origin", int'(pix_valid && pix_x == 0 && pix_y == 0), 1);
    end
    cur.vis = 1'b0; cur.x = 0; cur.y = 0; cur.r = '0; cur.g = '0; cur.b = '0;
    if (idle) begin
      hsync_in = 1'b1; vsync_in = 1'b1; r_in = '0; g_in = '0; b_in = '0;
    end else begin
      hsync_in = !(gh < HS);
      vsync_in = !(gv < vs_lines);
      cur.vis = (gh >= HS + HB) && (gh < HS + HB + HA) && (gv >= VS + VB) && (gv < VS + VB + VA);
      if (cur.vis) begin
        cur.x = gh - (HS + HB);
        cur.y = gv - (VS + VB);
        c = colour(cur.x, cur.y);
        cur.r = c[5:4]; cur.g = c[3:2]; cur.b = c[1:0];
      end
      r_in = cur.r; g_in = cur.g; b_in = cur.b;
      gh++;
      if (gh == HT + ((gv == long_line) ? 1 : 0)) begin
        gh = 0;
        gv++;
        if (gv == VT) begin
          gv = 0;
          frames_done++;
          last_fpix = fpix; last_ffs = ffs;
          fpix = 0; ffs = 0;
          long_line = -1; vs_lines = VS;
        end
      end
    end
    h2 = h1;
    h1 = cur;
  endtask

  task automatic run_frames(input int n);
    int target;
    target = frames_done + n;
    while (frames_done < target) step();
  endtask

  task automatic run_until(input int line, input int col);
    while (!(gv == line && gh == col)) step();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"ideal",      0, 1, 1, 0, HT, VT, HA*VA, 1};
    tbl[1] = '{"long_line",  1, 1, 0, 1, HT, VT, 2*HA,  1};
    tbl[2] = '{"relock",     0, 3, 1, 1, HT, VT, HA*VA, 1};
    tbl[3] = '{"sync_stall", 2, 3, 1, 2, HT, VT, HA*VA, 1};
    tbl[4] = '{"mid_reset",  4, 3, 1, 0, HT, VT, HA*VA, 1};
    tbl[5] = '{"wide_vsync", 3, 4, 1, 0, HT, VT, HA*VA, 1};

    checks = 0; errors = 0;
    gh = 0; gv = 0; long_line = -1; vs_lines = VS; frames_done = 0; idle = 1'b0;
    fpix = 0; ffs = 0; last_fpix = 0; last_ffs = 0;
    h1.vis = 1'b0; h2.vis = 1'b0;
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; r_in = '0; g_in = '0; b_in = '0;

    repeat (3) @(negedge clk);
    check("reset_locked", locked, 0);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_err_count", err_count, 0);
    check("reset_line_len", line_len_meas, 0);
    check("reset_frame_lines", frame_lines_meas, 0);
    rst = 1'b0;

    // Initial lock: rises exactly one clock after the third vsync fall reaches stage 1
    run_frames(2);
    step();
    step();
    check("lock_not_early", locked, 0);
    step();
    check("lock_rise_cycle", locked, 1);
    run_frames(1);

    for (int i = 0; i < 6; i++) begin
      case (tbl[i].mode)
        1: begin
          long_line = 5;
          run_until(6, 0);
          step();
          step();
          check("long_line_still_locked", locked, 1);
          step();
          check("long_line_lock_drop", locked, 0);
          check("long_line_err", err_count, 1);
          check("long_line_len", line_len_meas, HT + 1);
          run_frames(tbl[i].frames);
        end
        2: begin
          idle = 1'b1;
          for (int j = 0; j < 2100; j++) begin
            step();
            if (j == 2033) check("stall_before_timeout", locked, 1);
            if (j == 2034) begin
              check("stall_timeout_drop", locked, 0);
              check("stall_timeout_err", err_count, 2);
            end
          end
          idle = 1'b0;
          run_frames(tbl[i].frames);
        end
        3: begin
          run_until(5, 8);
          reset_pulse();
          run_frames(1);
          vs_lines = 3;
          run_frames(tbl[i].frames - 1);
          check("wide_vsync_delays_lock", locked, 0);
          run_frames(1);
        end
        4: begin
          run_until(5, 8);
          check("mid_reset_pre_locked", locked, 1);
          reset_pulse();
          check("mid_reset_locked", locked, 0);
          check("mid_reset_pix_valid", pix_valid, 0);
          check("mid_reset_pix_x", pix_x, 0);
          check("mid_reset_pix_y", pix_y, 0);
          check("mid_reset_err", err_count, 0);
          check("mid_reset_line_len", line_len_meas, 0);
          check("mid_reset_frame_lines", frame_lines_meas, 0);
          run_frames(1);
          run_frames(tbl[i].frames);
        end
        default: run_frames(tbl[i].frames);
      endcase
      check({tbl[i].name, "_locked"}, locked, tbl[i].exp_locked);
      check({tbl[i].name, "_err_count"}, err_count, tbl[i].exp_err);
      check({tbl[i].name, "_line_len"}, line_len_meas, tbl[i].exp_llm);
      check({tbl[i].name, "_frame_lines"}, frame_lines_meas, tbl[i].exp_flm);
      check({tbl[i].name, "_pixels"}, last_fpix, tbl[i].exp_pix);
      check({tbl[i].name, "_frame_starts"}, last_ffs, tbl[i].exp_fs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
